// File: rtl/order_compiler_mc_if.sv
// Request/order handshake bundle for the order compiler.
// The slave modport is the compiler side; the master modport is the driving side.
interface order_compiler_mc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int NUM_STOCKS = 4
);
  localparam int ID_WIDTH = $clog2(NUM_STOCKS);

  logic                  i_valid;
  logic                  o_ready;
  logic [ID_WIDTH-1:0]   i_stock_id;
  logic [DATA_WIDTH-1:0] i_mean;
  logic [DATA_WIDTH-1:0] i_stddev;
  logic [DATA_WIDTH-1:0] i_threshold;
  logic [DATA_WIDTH-1:0] i_current_price;
  logic [DATA_WIDTH-1:0] i_best_bid;
  logic [DATA_WIDTH-1:0] i_best_ask;
  logic [DATA_WIDTH-1:0] i_fixed_risk_limit;
  logic [QTY_WIDTH-1:0]  i_base_quantity;
  logic [DATA_WIDTH-1:0] i_max_position;
  logic [DATA_WIDTH-1:0] o_order_reg_1;
  logic [DATA_WIDTH-1:0] o_order_reg_2;
  logic                  o_valid;
  logic                  i_ready;

  modport slave (
    input  i_valid, i_stock_id, i_mean, i_stddev, i_threshold, i_current_price,
           i_best_bid, i_best_ask, i_fixed_risk_limit, i_base_quantity, i_max_position,
           i_ready,
    output o_ready, o_order_reg_1, o_order_reg_2, o_valid
  );

  modport master (
    output i_valid, i_stock_id, i_mean, i_stddev, i_threshold, i_current_price,
           i_best_bid, i_best_ask, i_fixed_risk_limit, i_base_quantity, i_max_position,
           i_ready,
    input  o_ready, o_order_reg_1, o_order_reg_2, o_valid
  );
endinterface

// File: rtl/order_compiler_mc.sv
// Mean-reversion order compiler: band decision, sequential risk sizing divider,
// per-stock position limiting and a held two-word order output.
module order_compiler_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int QTY_WIDTH  = 16,
  parameter int NUM_STOCKS = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  order_compiler_mc_if.slave               bus,
  output logic [NUM_STOCKS*DATA_WIDTH-1:0] o_positions
);
  localparam int ID_WIDTH = $clog2(NUM_STOCKS);
  localparam int W2       = 2 * DATA_WIDTH;
  localparam int UW       = W2 + 1;
  localparam int DEN_W    = DATA_WIDTH + QTY_WIDTH;
  localparam int HW       = DATA_WIDTH + 2;
  localparam int CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [QTY_WIDTH-1:0] QMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_DIV  = 3'd2,
    S_RISK = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                r_state, w_next;
  logic [ID_WIDTH-1:0]   r_stock_id;
  logic [DATA_WIDTH-1:0] r_mean, r_stddev, r_thr, r_price, r_bid, r_ask, r_limit, r_maxpos;
  logic [QTY_WIDTH-1:0]  r_base;
  logic                  r_side;
  logic [DEN_W-1:0]      r_den, r_rem;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [CW-1:0]         r_cnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_order1, r_order2;
  logic [DATA_WIDTH-1:0] r_pos [NUM_STOCKS];

  logic                  w_accept, w_handshake;
  logic [W2-1:0]         w_k;
  logic [UW-1:0]         w_upper;
  logic [DATA_WIDTH-1:0] w_lower;
  logic [DEN_W-1:0]      w_den;
  logic                  w_sell, w_buy, w_calc_hold;
  logic [DEN_W:0]        w_rem_sh;
  logic                  w_ge;
  logic [DEN_W-1:0]      w_rem_next;
  logic [DATA_WIDTH-1:0] w_pos_sel;
  logic [QTY_WIDTH-1:0]  w_qty_sat, w_risk_qty;
  logic signed [HW-1:0]  w_max_ext, w_pos_ext, w_head;
  logic [HW-1:0]         w_head_fl;
  logic                  w_risk_hold;

  function automatic logic [DATA_WIDTH-1:0] pack_order(
    input logic [ID_WIDTH-1:0]  id,
    input logic                 hold,
    input logic                 side,
    input logic [QTY_WIDTH-1:0] qty
  );
    logic [DATA_WIDTH-1:0] word;
    word                          = '0;
    word[QTY_WIDTH-1:0]           = qty;
    word[QTY_WIDTH]               = side;
    word[QTY_WIDTH+1]             = hold;
    word[QTY_WIDTH+2 +: ID_WIDTH] = id;
    return word;
  endfunction

  assign w_accept      = bus.i_valid && (r_state == S_IDLE);
  assign w_handshake   = r_valid && bus.i_ready;
  assign bus.o_ready   = (r_state == S_IDLE);
  assign bus.o_valid   = r_valid;
  assign bus.o_order_reg_1 = r_order1;
  assign bus.o_order_reg_2 = r_order2;

  // Band limits and decision; the upper band is one bit wider so it never wraps
  always_comb begin
    w_k     = W2'(r_thr) * W2'(r_stddev);
    w_upper = UW'(r_mean) + UW'(w_k);
    if (w_k > W2'(r_mean)) begin
      w_lower = '0;
    end else begin
      w_lower = r_mean - w_k[DATA_WIDTH-1:0];
    end
    w_den       = DEN_W'(r_stddev) * DEN_W'(r_base);
    w_sell      = UW'(r_price) > w_upper;
    w_buy       = r_price < w_lower;
    w_calc_hold = (w_den == '0) || !(w_sell || w_buy);
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    w_rem_sh = {r_rem, r_quot[DATA_WIDTH-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_den});
    if (w_ge) begin
      w_rem_next = w_rem_sh[DEN_W-1:0] - r_den;
    end else begin
      w_rem_next = w_rem_sh[DEN_W-1:0];
    end
  end

  // Quantity clamp against the quantity field and the remaining position headroom
  always_comb begin
    w_pos_sel = '0;
    for (int k = 0; k < NUM_STOCKS; k++) begin
      if (r_stock_id == ID_WIDTH'(k)) begin
        w_pos_sel = r_pos[k];
      end else begin
        w_pos_sel = w_pos_sel;
      end
    end
    if (r_quot > DATA_WIDTH'(QMAX)) begin
      w_qty_sat = QMAX;
    end else begin
      w_qty_sat = r_quot[QTY_WIDTH-1:0];
    end
    w_max_ext = $signed({2'b00, r_maxpos});
    w_pos_ext = $signed({{2{w_pos_sel[DATA_WIDTH-1]}}, w_pos_sel});
    if (r_side) begin
      w_head = w_max_ext + w_pos_ext;
    end else begin
      w_head = w_max_ext - w_pos_ext;
    end
    if (w_head[HW-1]) begin
      w_head_fl = '0;
    end else begin
      w_head_fl = w_head;
    end
    if (HW'(w_qty_sat) > w_head_fl) begin
      w_risk_qty = w_head_fl[QTY_WIDTH-1:0];
    end else begin
      w_risk_qty = w_qty_sat;
    end
    w_risk_hold = (w_risk_qty == '0);
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC: begin
        if (w_calc_hold) w_next = S_OUT;
        else             w_next = S_DIV;
      end
      S_DIV: begin
        if (r_cnt == CW'(DATA_WIDTH - 1)) w_next = S_RISK;
        else                              w_next = S_DIV;
      end
      S_RISK: w_next = S_OUT;
      S_OUT: begin
        if (bus.i_ready) w_next = S_IDLE;
        else             w_next = S_OUT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, decision latching and divider datapath
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_stock_id <= '0;
      r_mean     <= '0;
      r_stddev   <= '0;
      r_thr      <= '0;
      r_price    <= '0;
      r_bid      <= '0;
      r_ask      <= '0;
      r_limit    <= '0;
      r_base     <= '0;
      r_maxpos   <= '0;
      r_side     <= 1'b0;
      r_den      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_stock_id <= bus.i_stock_id;
            r_mean     <= bus.i_mean;
            r_stddev   <= bus.i_stddev;
            r_thr      <= bus.i_threshold;
            r_price    <= bus.i_current_price;
            r_bid      <= bus.i_best_bid;
            r_ask      <= bus.i_best_ask;
            r_limit    <= bus.i_fixed_risk_limit;
            r_base     <= bus.i_base_quantity;
            r_maxpos   <= bus.i_max_position;
          end
        end
        S_CALC: begin
          r_side <= w_sell;
          r_den  <= w_den;
          r_rem  <= '0;
          r_quot <= r_limit;
          r_cnt  <= '0;
        end
        S_DIV: begin
          r_rem  <= w_rem_next;
          r_quot <= {r_quot[DATA_WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Order words are loaded once on entry to OUT and held until taken
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid  <= 1'b0;
      r_order1 <= '0;
      r_order2 <= '0;
    end else if ((r_state == S_CALC) && w_calc_hold) begin
      r_valid  <= 1'b1;
      r_order1 <= pack_order(r_stock_id, 1'b1, 1'b0, '0);
      r_order2 <= '0;
    end else if (r_state == S_RISK) begin
      r_valid <= 1'b1;
      if (w_risk_hold) begin
        r_order1 <= pack_order(r_stock_id, 1'b1, 1'b0, '0);
        r_order2 <= '0;
      end else begin
        r_order1 <= pack_order(r_stock_id, 1'b0, r_side, w_risk_qty);
        r_order2 <= r_side ? r_bid : r_ask;
      end
    end else if (w_handshake) begin
      r_valid <= 1'b0;
    end
  end

  // Positions move only when a traded order is handed off
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_STOCKS; k++) r_pos[k] <= '0;
    end else if (w_handshake && !r_order1[QTY_WIDTH+1]) begin
      for (int k = 0; k < NUM_STOCKS; k++) begin
        if (r_stock_id == ID_WIDTH'(k)) begin
          if (r_order1[QTY_WIDTH]) begin
            r_pos[k] <= r_pos[k] - DATA_WIDTH'(r_order1[QTY_WIDTH-1:0]);
          end else begin
            r_pos[k] <= r_pos[k] + DATA_WIDTH'(r_order1[QTY_WIDTH-1:0]);
          end
        end
      end
    end
  end

  // Flattened position view
  always_comb begin
    o_positions = '0;
    for (int k = 0; k < NUM_STOCKS; k++) begin
      o_positions[k*DATA_WIDTH +: DATA_WIDTH] = r_pos[k];
    end
  end
endmodule

// File: tb/tb_order_compiler_mc.sv
// Randomized scoreboard bench for order_compiler_mc with a behavioural
// reference model of the trading rules and a decoupled output monitor.
module tb_order_compiler_mc;
  localparam int DW = 32;
  localparam int QW = 16;
  localparam int NS = 4;
  localparam int IW = 2;
  localparam int PW = NS * DW;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] mean, std, thr, price, bid, ask, lim;
    logic [QW-1:0] base;
    logic [DW-1:0] maxp;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    int            lat;
    int            acc;
    logic [PW-1:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PW-1:0] positions;
  always #5 clk = ~clk;

  order_compiler_mc_if #(.DATA_WIDTH(DW), .QTY_WIDTH(QW), .NUM_STOCKS(NS)) bus ();
  order_compiler_mc #(.DATA_WIDTH(DW), .QTY_WIDTH(QW), .NUM_STOCKS(NS)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .o_positions(positions)
  );

  int     n_checks = 0;
  int     n_err = 0;
  int     cyc = 0;
  exp_t   sb[$];
  longint mpos[NS];
  bit     in_reset = 1'b1;
  bit     rand_ready = 1'b0;
  int     stall_budget = 0;
  bit     have_cur = 1'b0;
  bit     pos_pending = 1'b0;
  exp_t   cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] pos_snapshot();
    logic [PW-1:0] p;
    for (int k = 0; k < NS; k++) p[k*DW +: DW] = 32'(mpos[k]);
    return p;
  endfunction

  // Reference model: band rule, integer division, clamps, position bookkeeping
  function automatic exp_t predict(input req_t r);
    exp_t e;
    logic [127:0] k, up, lo, den, q;
    longint qty, head;
    bit sell, buy, hold;
    k    = 128'(r.thr) * 128'(r.std);
    up   = 128'(r.mean) + k;
    lo   = (k > 128'(r.mean)) ? 128'd0 : 128'(r.mean) - k;
    den  = 128'(r.std) * 128'(r.base);
    sell = 128'(r.price) > up;
    buy  = 128'(r.price) < lo;
    qty  = 0;
    if (den == 128'd0 || !(sell || buy)) begin
      hold = 1'b1;
      e.lat = 1;
    end else begin
      e.lat = DW + 2;
      q = 128'(r.lim) / den;
      qty = (q > 128'd65535) ? 65535 : longint'(q);
      head = sell ? longint'(r.maxp) + mpos[r.id] : longint'(r.maxp) - mpos[r.id];
      if (head < 0) head = 0;
      if (qty > head) qty = head;
      hold = (qty == 0);
      if (!hold) mpos[r.id] = sell ? mpos[r.id] - qty : mpos[r.id] + qty;
    end
    if (hold) begin
      e.r1 = (32'(r.id) << (QW + 2)) | (32'd1 << (QW + 1));
      e.r2 = 32'd0;
    end else begin
      e.r1 = (32'(r.id) << (QW + 2)) | (32'(sell) << QW) | 32'(qty);
      e.r2 = sell ? r.bid : r.ask;
    end
    e.pos = pos_snapshot();
    e.acc = 0;
    return e;
  endfunction

  function automatic req_t mk(input int id, input int mean, input int std, input int thr,
                              input int price, input int bid, input int ask,
                              input logic [31:0] lim, input int base, input int maxp);
    req_t r;
    r.id = IW'(id); r.mean = 32'(mean); r.std = 32'(std); r.thr = 32'(thr);
    r.price = 32'(price); r.bid = 32'(bid); r.ask = 32'(ask); r.lim = lim;
    r.base = QW'(base); r.maxp = 32'(maxp);
    return r;
  endfunction

  task automatic drive(input req_t r, input logic v);
    bus.i_valid = v; bus.i_stock_id = r.id; bus.i_mean = r.mean; bus.i_stddev = r.std;
    bus.i_threshold = r.thr; bus.i_current_price = r.price; bus.i_best_bid = r.bid;
    bus.i_best_ask = r.ask; bus.i_fixed_risk_limit = r.lim; bus.i_base_quantity = r.base;
    bus.i_max_position = r.maxp;
  endtask

  function automatic req_t rnd_req();
    req_t r;
    r.id = IW'($urandom_range(0, NS - 1));
    r.mean = 32'($urandom_range(100, 1000));
    r.std = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
    r.thr = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 7))
      0: r.price = r.mean + r.thr * r.std;
      1: r.price = r.mean - r.thr * r.std;
      default: r.price = r.mean - 32'd80 + 32'($urandom_range(0, 160));
    endcase
    r.lim = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 5000));
    r.base = QW'($urandom_range(0, 8));
    r.maxp = ($urandom_range(0, 7) == 0) ? 32'd100000 : 32'($urandom_range(0, 300));
    r.bid = $urandom; r.ask = $urandom;
    return r;
  endfunction

  task automatic send(input req_t r);
    exp_t e;
    int t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) chk("ready_timeout", {127'd0, bus.o_ready}, 128'd1);
    drive(r, 1'b1);
    @(negedge clk);
    drive(r, 1'b0);
    e = predict(r);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || have_cur || pos_pending || !bus.o_ready) && t < 2000) begin
      @(negedge clk); t++;
    end
    if (t >= 2000) chk("idle_timeout", PW'(sb.size()), '0);
  endtask

  // Monitor: pops the scoreboard when an order appears, checks hold-stability and positions
  initial begin
    forever begin
      @(negedge clk);
      if (in_reset || !rst_n) begin
        have_cur = 1'b0; pos_pending = 1'b0;
      end else begin
        if (pos_pending) begin
          chk("positions", positions, cur.pos);
          pos_pending = 1'b0;
        end
        if (bus.o_valid && !have_cur) begin
          if (sb.size() == 0) begin
            chk("unexpected_output", PW'(bus.o_order_reg_1), '0);
            chk("unexpected_output_valid", {127'd0, bus.o_valid}, '0);
          end else begin
            cur = sb.pop_front();
            have_cur = 1'b1;
            chk("order_reg_1", PW'(bus.o_order_reg_1), PW'(cur.r1));
            chk("order_reg_2", PW'(bus.o_order_reg_2), PW'(cur.r2));
            chk("latency", PW'(cyc - cur.acc), PW'(cur.lat));
            chk("ready_in_out", {127'd0, bus.o_ready}, '0);
          end
        end else if (bus.o_valid && have_cur) begin
          chk("hold_reg_1", PW'(bus.o_order_reg_1), PW'(cur.r1));
          chk("hold_reg_2", PW'(bus.o_order_reg_2), PW'(cur.r2));
        end
        if (bus.o_valid && bus.i_ready && have_cur) begin
          have_cur = 1'b0;
          pos_pending = 1'b1;
        end
      end
    end
  end

  // Downstream ready: forced stalls, random back-pressure or always ready
  initial begin
    bus.i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.o_valid && stall_budget > 0) begin
        bus.i_ready = 1'b0;
        stall_budget--;
      end else if (rand_ready) begin
        bus.i_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.i_ready = 1'b1;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_t r;
    int t;
    for (int k = 0; k < NS; k++) mpos[k] = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0), 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    chk("rst_valid", {127'd0, bus.o_valid}, '0);
    chk("rst_reg_1", PW'(bus.o_order_reg_1), '0);
    chk("rst_reg_2", PW'(bus.o_order_reg_2), '0);
    chk("rst_positions", positions, '0);
    chk("rst_ready", {127'd0, bus.o_ready}, 128'd1);

    send(mk(2, 100, 5, 2, 120, 119, 121, 32'd1000, 4, 1000));
    wait_idle();
    chk("pos2_first_sell", PW'(positions[2*DW +: DW]), PW'(32'hFFFF_FFCE));
    send(mk(2, 100, 5, 2, 105, 119, 121, 32'd1000, 4, 1000));
    send(mk(2, 100, 5, 2, 120, 119, 121, 32'd1000, 4, 60));
    send(mk(2, 100, 5, 2, 120, 119, 121, 32'd1000, 4, 60));
    wait_idle();
    chk("pos2_clipped", PW'(positions[2*DW +: DW]), PW'(32'hFFFF_FFC4));
    send(mk(1, 100, 5, 2, 80, 79, 81, 32'd1000, 4, 1000));
    wait_idle();
    chk("pos1_buy", PW'(positions[1*DW +: DW]), PW'(32'd50));
    send(mk(0, 100, 0, 2, 150, 1, 2, 32'd1000, 4, 1000));
    send(mk(0, 5, 5, 2, 0, 1, 2, 32'd1000, 4, 1000));
    send(mk(3, 100, 1, 1, 200, 7, 9, 32'hFFFF_FFFF, 1, 100000));
    send(mk(0, 100, 5, 2, 110, 1, 2, 32'd1000, 4, 1000));
    send(mk(0, 100, 5, 2, 90, 1, 2, 32'd1000, 4, 1000));
    wait_idle();

    stall_budget = 5;
    send(mk(0, 100, 5, 2, 50, 49, 51, 32'd500, 2, 1000));
    t = 0;
    while (!bus.o_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("stall_valid_timeout", {127'd0, bus.o_valid}, 128'd1);
    for (int i = 0; i < 3; i++) begin
      drive(rnd_req(), 1'b1);
      chk("stall_ready_low", {127'd0, bus.o_ready}, '0);
      @(negedge clk);
    end
    drive(mk(0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0), 1'b0);
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) send(rnd_req());
    wait_idle();
    rand_ready = 1'b0;
    @(negedge clk);
    chk("positions_after_random", positions, pos_snapshot());

    send(mk(0, 100, 5, 2, 120, 119, 121, 32'd1000, 4, 1000));
    repeat (10) @(negedge clk);
    in_reset = 1'b1;
    rst_n = 1'b0;
    sb.delete();
    for (int k = 0; k < NS; k++) mpos[k] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    in_reset = 1'b0;
    chk("abort_valid", {127'd0, bus.o_valid}, '0);
    chk("abort_positions", positions, '0);
    chk("abort_ready", {127'd0, bus.o_ready}, 128'd1);
    repeat (40) @(negedge clk);
    chk("abort_no_output", {127'd0, bus.o_valid}, '0);
    send(mk(1, 100, 5, 2, 80, 79, 81, 32'd1000, 4, 1000));
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
